// File: rtl/sram_pkg.sv
// Shared SRAM definitions: bus widths common to the SRAM controller and the
// responder model, plus the responder state encoding.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2,
        DRIVE  = 2'd3
    } sram_state_e;

    // Settle counter step that stops at the read latency.
    function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
        return (v >= lim) ? lim : v + 3'd1;
    endfunction

endpackage

// File: rtl/sram_array.sv
// MEM_WORDS x DATA_WIDTH storage: one synchronous write port and one
// synchronous read port whose data output is registered.
module sram_array #(
    parameter int MEM_WORDS  = 262144,
    parameter int DATA_WIDTH = 16,
    localparam int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset so they survive rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Synthesizable stand-in for the external 16-bit SRAM on the shared DQ bus.
// Optional bus-misuse detection is enabled by defining SRAM_CONTENTION_CHECK_EN.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH   = SRAM_ADDR_W,
    parameter int DATA_WIDTH   = SRAM_DATA_W,
    parameter int MEM_WORDS    = 262144,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    input  logic                  SRAM_WE_N,
    inout  wire  [DATA_WIDTH-1:0] SRAM_DQ,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic                  bus_error
);

    localparam int         IDX_W = $clog2(MEM_WORDS);
    localparam logic [2:0] RL    = 3'(READ_LATENCY);

    sram_state_e           state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           wr_count_q, rd_count_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [IDX_W-1:0]      idx;
    logic                  write_edge, new_addr, load, rd_entry, drive_en;

    assign idx        = SRAM_ADDR[IDX_W-1:0];
    // Only a solid 0 writes; z or x on WE_N is treated as idle.
    assign write_edge = (SRAM_WE_N === 1'b0);
    assign new_addr   = (SRAM_ADDR != addr_q) || (state_q == IDLE) || (state_q == WRITE);

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (write_edge) begin
            cnt_d   = 3'd0;
            state_d = WRITE;
        end else begin
            cnt_d   = new_addr ? 3'd1 : sat_inc(cnt_q, RL);
            state_d = (cnt_d == RL) ? DRIVE : SETTLE;
        end
    end

    assign load     = !write_edge && (cnt_d == RL);
    assign rd_entry = load && !((state_q == DRIVE) && !new_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            wr_count_q <= 16'd0;
            rd_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= SRAM_ADDR;
            if (write_edge) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (rd_entry) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    sram_array #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we_i   (write_edge),
        .waddr_i(idx),
        .wdata_i(SRAM_DQ),
        .re_i   (load),
        .raddr_i(idx),
        .rdata_o(rd_data)
    );

    // Combinational release: the bus lets go in the same cycle WE_N drops or the address moves.
    assign drive_en = (state_q == DRIVE) && (SRAM_WE_N !== 1'b0) && (SRAM_ADDR == addr_q);
    assign SRAM_DQ  = drive_en ? rd_data : {DATA_WIDTH{1'bz}};

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

`ifdef SRAM_CONTENTION_CHECK_EN
    logic bus_error_q;

    // The foreign-driver check only applies while this model is actually driving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_error_q <= 1'b0;
        end else if ((write_edge && $isunknown(SRAM_DQ)) ||
                     (drive_en && (SRAM_DQ !== rd_data))) begin
            bus_error_q <= 1'b1;
        end
    end

    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Randomized scoreboard bench: two responders (read latency 1 and 3, 1024 words)
// share one stimulus stream and are checked against a cycle-level behavioural model.
module tb_sram_responder;

    localparam int MEMW = 1024;

    typedef struct {
        bit          drive;
        logic [15:0] val;
        logic [15:0] wr;
        logic [15:0] rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [17:0] addr;
    logic        we_n;
    logic        tb_en;
    logic [15:0] tb_dat;
    wire  [15:0] dq0, dq1;
    logic [15:0] wr0, rd0, wr1, rd1;
    logic        be0, be1;

    assign dq0 = tb_en ? tb_dat : 16'hzzzz;
    assign dq1 = tb_en ? tb_dat : 16'hzzzz;

    sram_responder #(
        .ADDR_WIDTH(18), .DATA_WIDTH(16), .MEM_WORDS(MEMW), .READ_LATENCY(1)
    ) u_rl1 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_WE_N(we_n), .SRAM_DQ(dq0),
        .wr_count(wr0), .rd_count(rd0), .bus_error(be0)
    );

    sram_responder #(
        .ADDR_WIDTH(18), .DATA_WIDTH(16), .MEM_WORDS(MEMW), .READ_LATENCY(3)
    ) u_rl3 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_WE_N(we_n), .SRAM_DQ(dq1),
        .wr_count(wr1), .rd_count(rd1), .bus_error(be1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Behavioural model: memory image, consecutive stable-read-edge runs, counters.
    logic [15:0] mem_m [MEMW];
    int          run_m [2];
    bit          fresh_m;
    logic [17:0] prev_a_m;
    logic [15:0] wr_m;
    logic [15:0] rd_m  [2];
    logic        err_m [2];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // A released bus reads as z (4-state) or as 0 (2-state); stored data is never 0.
    function automatic bit released(input logic [15:0] v);
        return (v === 16'h0000) || $isunknown(v);
    endfunction

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rel(input string name, input logic [15:0] act);
        total++;
        if (!released(act)) begin
            bad++;
            $display("FAIL %s: got %h want released bus at %0t", name, act, $time);
        end
    endtask

    task automatic model_reset();
        fresh_m = 1'b1;
        prev_a_m = '0;
        wr_m = 16'd0;
        for (int k = 0; k < 2; k++) begin
            run_m[k] = 0;
            rd_m[k]  = 16'd0;
            err_m[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit we_n_v, input logic [17:0] a, input logic [15:0] d,
                              input bit contend);
        int   i;
        exp_t e;
        i = int'(a) % MEMW;
        for (int k = 0; k < 2; k++) begin
            if (contend && we_n_v && !fresh_m && a == prev_a_m && run_m[k] >= lat(k))
                err_m[k] = 1'b1;
        end
        if (!we_n_v) begin
            mem_m[i] = d;
            wr_m = wr_m + 16'd1;
            run_m[0] = 0;
            run_m[1] = 0;
            fresh_m = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                run_m[k] = (fresh_m || a != prev_a_m) ? 1 : run_m[k] + 1;
                if (run_m[k] == lat(k)) rd_m[k] = rd_m[k] + 16'd1;
            end
            fresh_m = 1'b0;
        end
        prev_a_m = a;
        for (int k = 0; k < 2; k++) begin
            e.drive = we_n_v && (run_m[k] >= lat(k));
            e.val   = mem_m[i];
            e.wr    = wr_m;
            e.rd    = rd_m[k];
            e.err   = err_m[k];
            if (k == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
    endtask

    // One bus cycle; called just after a falling edge, returns just after the next one.
    task automatic cycle(input bit we_n_v, input logic [17:0] a, input logic [15:0] d,
                         input bit contend);
        txn++;
        $display("txn %0d we_n=%0b addr=%05h data=%04h contend=%0b", txn, we_n_v, a, d, contend);
        addr = a;
        if (!we_n_v) begin
            we_n  = 1'b0;
            tb_en = 1'b0;
            #1;
            check_rel("wr_release_rl1", dq0);
            check_rel("wr_release_rl3", dq1);
            tb_dat = d;
            tb_en  = 1'b1;
        end else begin
            we_n = 1'b1;
            if (contend) begin
                tb_dat = 16'h5555;
                tb_en  = 1'b1;
            end
        end
        @(posedge clk);
        model_edge(we_n_v, a, d, contend);
        #1 tb_en = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic compare_exp(input string tag, input exp_t e, input logic [15:0] dq,
                               input logic [15:0] wr, input logic [15:0] rd, input logic be);
        if (e.drive) check_val({tag, "_dq"}, dq, e.val);
        else         check_rel({tag, "_dq_release"}, dq);
        check_val({tag, "_wr_count"}, wr, e.wr);
        check_val({tag, "_rd_count"}, rd, e.rd);
        check_val({tag, "_bus_error"}, {15'd0, be}, {15'd0, e.err});
    endtask

    // Monitor: pops one expectation per responder at every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            compare_exp("rl1", e, dq0, wr0, rd0, be0);
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            compare_exp("rl3", e, dq1, wr1, rd1, be1);
        end
    end

    function automatic logic [17:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 18'h00010;
            1: return 18'h00400;
            2: return 18'h00000;
            3: return 18'h3FC05;
            default: return 18'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] rnd_data();
        return 16'($urandom_range(1, 65535));
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] a;
        int          h;
        int          nw;

        rst = 1'b1; we_n = 1'b1; addr = '0; tb_en = 1'b0; tb_dat = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_rel("reset_dq_rl1", dq0);
        check_val("reset_wr_count", wr0, 16'd0);
        check_val("reset_rd_count", rd1, 16'd0);
        check_val("reset_bus_error", {15'd0, be1}, 16'd0);
        rst = 1'b0;

        // Fill every word (with random aliasing upper address bits) so all reads are known.
        for (int i = 0; i < MEMW; i++)
            cycle(1'b0, 18'(i + MEMW * $urandom_range(0, 255)), rnd_data(), 1'b0);

        // Reset in the middle of a driven read.
        for (int j = 0; j < 4; j++) cycle(1'b1, 18'h00005, 16'h0, 1'b0);
        rst = 1'b1;
        #1;
        check_rel("rst_mid_read_rl1", dq0);
        check_rel("rst_mid_read_rl3", dq1);
        check_val("rst_mid_read_rd_count", rd0, 16'd0);
        check_val("rst_mid_read_wr_count", wr1, 16'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Write then read back with latency 1 and 3.
        cycle(1'b0, 18'h00010, 16'hBEEF, 1'b0);
        cycle(1'b1, 18'h00010, 16'h0, 1'b0);
        check_val("wr_rd_beef_rl1", dq0, 16'hBEEF);
        check_val("wr_rd_rd_count", rd0, 16'd1);
        check_val("wr_rd_wr_count", wr0, 16'd1);
        check_rel("wr_rd_settle_rl3", dq1);
        cycle(1'b1, 18'h00010, 16'h0, 1'b0);
        cycle(1'b1, 18'h00010, 16'h0, 1'b0);
        check_val("wr_rd_beef_rl3", dq1, 16'hBEEF);

        // Address moving every 2 cycles never satisfies latency 3.
        for (int j = 0; j < 6; j++) begin
            a = (j % 2 == 0) ? 18'h00123 : 18'h00321;
            cycle(1'b1, a, 16'h0, 1'b0);
            check_rel("latency_unstable_rl3", dq1);
            cycle(1'b1, a, 16'h0, 1'b0);
            check_rel("latency_unstable_rl3", dq1);
        end

        // Turnaround: write over a driven read, then read the new word.
        for (int j = 0; j < 3; j++) cycle(1'b1, 18'h00020, 16'h0, 1'b0);
        cycle(1'b0, 18'h00020, 16'h1234, 1'b0);
        for (int j = 0; j < 3; j++) cycle(1'b1, 18'h00020, 16'h0, 1'b0);
        check_val("turnaround_rl3", dq1, 16'h1234);
        check_val("turnaround_bus_error", {15'd0, be0}, 16'd0);

        // Address wrap at MEM_WORDS.
        cycle(1'b0, 18'h00400, 16'hAAAA, 1'b0);
        for (int j = 0; j < 3; j++) cycle(1'b1, 18'h00000, 16'h0, 1'b0);
        check_val("wrap_rl3", dq1, 16'hAAAA);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                nw = $urandom_range(1, 3);
                for (int j = 0; j < nw; j++) cycle(1'b0, pick_addr(), rnd_data(), 1'b0);
            end else begin
                a = pick_addr();
                h = $urandom_range(1, 6);
                for (int j = 0; j < h; j++) cycle(1'b1, a, 16'h0, 1'b0);
            end
        end

`ifdef SRAM_CONTENTION_CHECK_EN
        cycle(1'b0, 18'h00077, 16'h0001, 1'b0);
        for (int j = 0; j < 3; j++) cycle(1'b1, 18'h00077, 16'h0, 1'b0);
        cycle(1'b1, 18'h00077, 16'h0, 1'b1);
        for (int j = 0; j < 3; j++) cycle(1'b1, pick_addr(), 16'h0, 1'b0);
        check_val("contention_sticky_rl1", {15'd0, be0}, 16'd1);
        check_val("contention_sticky_rl3", {15'd0, be1}, 16'd1);
        rst = 1'b1;
        #1;
        check_val("contention_cleared", {15'd0, be0}, 16'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        model_reset();
`endif

        for (int j = 0; j < 3; j++) cycle(1'b1, 18'h00010, 16'h0, 1'b0);
        @(negedge clk);
        #1;
        check_val("scoreboard_drained", 16'(exp_q0.size() + exp_q1.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
